// File: rtl/sup_counter_pkg.sv
// Shared constants for the supervised counter: overflow modes and parameter defaults.
package sup_counter_pkg;

  typedef enum logic {
    WRAP = 1'b0,
    SAT  = 1'b1
  } mode_e;

  localparam int DEF_WIDTH = 3;
  localparam int DEF_MAXV  = 7;
  localparam int DEF_DIV   = 1;

endpackage

// File: rtl/sup_prescaler.sv
// Enable prescaler: emits one tick per DIV enabled cycles; restart forces it back to phase 0.
module sup_prescaler
  import sup_counter_pkg::*;
#(
  parameter int DIV = DEF_DIV
) (
  input  logic c,
  input  logic r,
  input  logic en,
  input  logic restart,
  output logic tick
);

  // A one-bit phase register is kept even for DIV=1; it then never leaves 0.
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge c) begin
    if (r || restart) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + PW'(1);
    end
  end

endmodule

// File: rtl/sup_counter.sv
// Modulo-(MAXV+1) counter with prescaled enable, clamped parallel load,
// wrap/saturate overflow mode and a sticky overflow flag.
module sup_counter
  import sup_counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int MAXV  = DEF_MAXV,
  parameter int DIV   = DEF_DIV
) (
  input  logic             c,
  input  logic             r,
  input  logic             en,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic             sat,
  input  logic             clr,
  output logic [WIDTH-1:0] c0,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MAXV);

  logic             tick;
  logic [WIDTH-1:0] c0_next;
  logic             ovf_next;

  sup_prescaler #(.DIV(DIV)) u_prescaler (
    .c       (c),
    .r       (r),
    .en      (en),
    .restart (ld),
    .tick    (tick)
  );

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    c0_next  = c0;
    ovf_next = ovf & ~clr;
    if (ld) begin
      c0_next = (d > MAX) ? MAX : d;
    end else if (tick) begin
      if (c0 < MAX) begin
        c0_next = c0 + WIDTH'(1);
      end else begin
        // An overflow event beats a simultaneous clear.
        ovf_next = 1'b1;
        c0_next  = (mode_e'(sat) == SAT) ? MAX : '0;
      end
    end
  end

  always_ff @(posedge c) begin
    if (r) begin
      c0  <= '0;
      ovf <= 1'b0;
    end else begin
      c0  <= c0_next;
      ovf <= ovf_next;
    end
  end

  assign tc = (c0 == MAX);

endmodule

// File: tb/tb_sup_counter.sv
// Directed self-checking bench: three sup_counter builds (defaults, MAXV=5, DIV=3) on shared stimulus.
module tb_sup_counter;

  logic       c = 1'b0;
  logic       r, en, ld, sat, clr;
  logic [2:0] d;

  logic [2:0] c0_def, c0_m5, c0_d3;
  logic       tc_def, tc_m5, tc_d3;
  logic       ovf_def, ovf_m5, ovf_d3;

  int checks = 0;
  int errors = 0;

  always #5 c = ~c;

  sup_counter u_def (
    .c(c), .r(r), .en(en), .ld(ld), .d(d), .sat(sat), .clr(clr),
    .c0(c0_def), .tc(tc_def), .ovf(ovf_def)
  );

  sup_counter #(.WIDTH(3), .MAXV(5), .DIV(1)) u_m5 (
    .c(c), .r(r), .en(en), .ld(ld), .d(d), .sat(sat), .clr(clr),
    .c0(c0_m5), .tc(tc_m5), .ovf(ovf_m5)
  );

  sup_counter #(.WIDTH(3), .MAXV(7), .DIV(3)) u_d3 (
    .c(c), .r(r), .en(en), .ld(ld), .d(d), .sat(sat), .clr(clr),
    .c0(c0_d3), .tc(tc_d3), .ovf(ovf_d3)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge and settle outputs before sampling.
  task automatic step();
    @(posedge c);
    #1;
  endtask

  task automatic do_reset();
    r = 1'b1; en = 1'b0; ld = 1'b0; clr = 1'b0; sat = 1'b0; d = 3'd0;
    step();
    r = 1'b0;
  endtask

  initial begin
    r = 1'b1; en = 1'b0; ld = 1'b0; d = 3'd0; sat = 1'b0; clr = 1'b0;

    // Reset state, even with ld/en/clr asserted.
    ld = 1'b1; d = 3'd4; en = 1'b1; clr = 1'b1;
    step();
    check("rst_c0", c0_def, 0);
    check("rst_ovf", ovf_def, 0);
    check("rst_tc", tc_def, 0);
    check("rst_d3_c0", c0_d3, 0);

    // Free-run wrap with defaults.
    do_reset();
    en = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step();
      check($sformatf("run_c0_%0d", i), c0_def, i % 8);
      check($sformatf("run_ovf_%0d", i), ovf_def, (i >= 8) ? 1 : 0);
      check($sformatf("run_tc_%0d", i), tc_def, ((i % 8) == 7) ? 1 : 0);
    end

    // Saturate mode after a load of 5.
    do_reset();
    sat = 1'b1; ld = 1'b1; d = 3'd5;
    step();
    check("sat_ld_c0", c0_def, 5);
    ld = 1'b0; en = 1'b1;
    step(); check("sat_c0_1", c0_def, 6); check("sat_ovf_1", ovf_def, 0);
    step(); check("sat_c0_2", c0_def, 7); check("sat_ovf_2", ovf_def, 0);
    step(); check("sat_c0_3", c0_def, 7); check("sat_ovf_3", ovf_def, 1);
    step(); check("sat_c0_4", c0_def, 7); check("sat_tc_4", tc_def, 1);
    // Mode change acts on the very next tick.
    sat = 1'b0;
    step(); check("sat_off_c0", c0_def, 0); check("sat_off_ovf", ovf_def, 1);

    // Load clamp with MAXV=5.
    do_reset();
    ld = 1'b1; d = 3'b111;
    step();
    check("clamp_c0", c0_m5, 5);
    check("clamp_tc", tc_m5, 1);
    check("clamp_ovf", ovf_m5, 0);
    check("noclamp_c0", c0_def, 7);
    // Wrap at MAXV=5, not at 7.
    ld = 1'b0; en = 1'b1;
    step();
    check("m5_wrap_c0", c0_m5, 0);
    check("m5_wrap_ovf", ovf_m5, 1);

    // DIV=3 prescaling and en gaps mid-prescale.
    do_reset();
    en = 1'b1;
    step(); check("div_c0_1", c0_d3, 0);
    step(); check("div_c0_2", c0_d3, 0);
    step(); check("div_c0_3", c0_d3, 1);
    step(); check("div_c0_4", c0_d3, 1);
    en = 1'b0;
    step(); check("div_hold_5", c0_d3, 1);
    step(); check("div_hold_6", c0_d3, 1);
    en = 1'b1;
    step(); check("div_c0_7", c0_d3, 1);
    step(); check("div_c0_8", c0_d3, 2);

    // Clear versus overflow on the same edge, load never sets ovf.
    do_reset();
    ld = 1'b1; d = 3'd7;
    step();
    check("clr_ld_ovf", ovf_def, 0);
    ld = 1'b0; en = 1'b1;
    step(); check("clr_wrap_c0", c0_def, 0); check("clr_wrap_ovf", ovf_def, 1);
    en = 1'b0; ld = 1'b1; d = 3'd7;
    step(); check("clr_reld_c0", c0_def, 7);
    ld = 1'b0; en = 1'b1; clr = 1'b1;
    step(); check("clr_race_c0", c0_def, 0); check("clr_race_ovf", ovf_def, 1);
    en = 1'b0;
    step(); check("clr_only_ovf", ovf_def, 0); check("clr_only_c0", c0_def, 0);
    clr = 1'b0; ld = 1'b1; d = 3'd7;
    step();
    ld = 1'b0; en = 1'b1;
    step(); check("ldclr_pre_ovf", ovf_def, 1);
    en = 1'b0; ld = 1'b1; clr = 1'b1; d = 3'd2;
    step(); check("ldclr_c0", c0_def, 2); check("ldclr_ovf", ovf_def, 0);
    ld = 1'b0; clr = 1'b0;

    // Reset wins over load and count, and discards prescaler progress.
    do_reset();
    ld = 1'b1; d = 3'd6;
    step();
    ld = 1'b0; en = 1'b1;
    step(); check("mid_d3_c0", c0_d3, 6);
    r = 1'b1; ld = 1'b1; d = 3'd4; en = 1'b1;
    step();
    check("rmid_d3_c0", c0_d3, 0); check("rmid_d3_ovf", ovf_d3, 0);
    check("rmid_def_c0", c0_def, 0); check("rmid_def_ovf", ovf_def, 0);
    r = 1'b0; ld = 1'b0;
    step(); check("rel_d3_1", c0_d3, 0); check("rel_def_1", c0_def, 1);
    step(); check("rel_d3_2", c0_d3, 0);
    step(); check("rel_d3_3", c0_d3, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
